// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants and the coordinate type.
// Used by vga_axis_counter and vga_scan_timing.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_TOTAL   = 800;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_TOTAL   = 525;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one scan axis (horizontal or vertical) of the raster.
// Ports:
//   vga_clk, reset   pixel clock, async active-high reset
//   en               count enable (advance one position)
//   count            registered coordinate, 0..TOTAL-1
//   wrap_c           count is at TOTAL-1 and advancing (next value is 0)
//   active_c         next coordinate lies in the visible region
//   sync_active_c    next coordinate lies in the sync pulse window
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned VISIBLE = 640,
  parameter int unsigned FP      = 16,
  parameter int unsigned SYNC    = 96,
  parameter int unsigned TOTAL   = 800
) (
  input  logic   vga_clk,
  input  logic   reset,
  input  logic   en,
  output coord_t count,
  output logic   wrap_c,
  output logic   active_c,
  output logic   sync_active_c
);

  coord_t count_nxt;

  // Next-position logic; decodes are taken from the next value so the
  // registered outputs in the parent line up with the registered count.
  always_comb begin
    count_nxt     = count;
    wrap_c        = en && (count == coord_t'(TOTAL - 1));
    if (wrap_c) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = count + coord_t'(1);
    end
    active_c      = (count_nxt < coord_t'(VISIBLE));
    sync_active_c = (count_nxt >= coord_t'(VISIBLE + FP)) &&
                    (count_nxt <  coord_t'(VISIBLE + FP + SYNC));
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_scan_timing.sv
// vga_scan_timing: VGA raster scan generator (pixel coordinates, blanking,
// syncs and frame/line markers), all outputs registered and coincident with
// DrawX/DrawY. hs_d/vs_d are the syncs delayed one pixel for a registered
// RGB pipeline.
// Optional build macro VGA_FRAME_COUNTER_EN adds a 16-bit frame counter
// output frame_cnt.
// Ports:
//   vga_clk, reset      pixel clock, async active-high reset
//   DrawX, DrawY        current pixel / line coordinate
//   blank               1 = visible pixel
//   hs, vs              active-low syncs; hs_d, vs_d one-cycle delayed copies
//   frame_start         pulse at (0,0); line_end pulse at last pixel of a line
//   frame_cnt           (VGA_FRAME_COUNTER_EN only) frames started since reset
module vga_scan_timing
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VIS  = H_VISIBLE,
  parameter int unsigned H_FPW  = H_FP,
  parameter int unsigned H_SYW  = H_SYNC,
  parameter int unsigned H_TOT  = H_TOTAL,
  parameter int unsigned V_VIS  = V_VISIBLE,
  parameter int unsigned V_FPW  = V_FP,
  parameter int unsigned V_SYW  = V_SYNC,
  parameter int unsigned V_TOT  = V_TOTAL
) (
  input  logic        vga_clk,
  input  logic        reset,
  output coord_t      DrawX,
  output coord_t      DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        hs_d,
  output logic        vs_d,
  output logic        frame_start,
  output logic        line_end
`ifdef VGA_FRAME_COUNTER_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  logic h_wrap_c, h_active_c, h_sync_c;
  logic v_wrap_c, v_active_c, v_sync_c;

  vga_axis_counter #(
    .VISIBLE (H_VIS),
    .FP      (H_FPW),
    .SYNC    (H_SYW),
    .TOTAL   (H_TOT)
  ) u_h_axis (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .en            (1'b1),
    .count         (DrawX),
    .wrap_c        (h_wrap_c),
    .active_c      (h_active_c),
    .sync_active_c (h_sync_c)
  );

  vga_axis_counter #(
    .VISIBLE (V_VIS),
    .FP      (V_FPW),
    .SYNC    (V_SYW),
    .TOTAL   (V_TOT)
  ) u_v_axis (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .en            (h_wrap_c),
    .count         (DrawY),
    .wrap_c        (v_wrap_c),
    .active_c      (v_active_c),
    .sync_active_c (v_sync_c)
  );

  // Output decode registered from next-state values. DrawX advances every
  // cycle, so the next pixel is the last one exactly when DrawX = H_TOT-2;
  // v_wrap_c already implies the horizontal wrap, so its next state is (0,0).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      blank       <= 1'b1;
      hs          <= 1'b1;
      vs          <= 1'b1;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
    end else begin
      blank       <= h_active_c && v_active_c;
      hs          <= ~h_sync_c;
      vs          <= ~v_sync_c;
      hs_d        <= hs;
      vs_d        <= vs;
      frame_start <= v_wrap_c;
      line_end    <= (DrawX == coord_t'(H_TOT - 2));
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  // Steps together with frame_start; wraps naturally at 16 bits.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (v_wrap_c) begin
      frame_cnt <= frame_cnt + 16'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vga_scan_timing.sv
// tb_vga_scan_timing: directed self-checking bench. A full-size instance
// checks reset, line timing and horizontal sync; a reduced-timing instance
// (16 x 10 raster: visible 8x4, hsync x=10..12, vsync y=6..7) exercises
// vertical sync, frame wrap and frame counting in a short run.
module tb_vga_scan_timing;
  import vga_timing_pkg::*;

  logic   vga_clk = 1'b0;
  logic   reset   = 1'b1;

  coord_t DrawX, DrawY;
  logic   blank, hs, vs, hs_d, vs_d, frame_start, line_end;
  coord_t m_DrawX, m_DrawY;
  logic   m_blank, m_hs, m_vs, m_hs_d, m_vs_d, m_frame_start, m_line_end;
`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frame_cnt, m_frame_cnt;
`endif

  int tests  = 0;
  int errors = 0;

  always #20 vga_clk = ~vga_clk;

  vga_scan_timing u_dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .hs_d        (hs_d),
    .vs_d        (vs_d),
    .frame_start (frame_start),
    .line_end    (line_end)
`ifdef VGA_FRAME_COUNTER_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  vga_scan_timing #(
    .H_VIS (8), .H_FPW (2), .H_SYW (3), .H_TOT (16),
    .V_VIS (4), .V_FPW (2), .V_SYW (2), .V_TOT (10)
  ) u_mini (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .DrawX       (m_DrawX),
    .DrawY       (m_DrawY),
    .blank       (m_blank),
    .hs          (m_hs),
    .vs          (m_vs),
    .hs_d        (m_hs_d),
    .vs_d        (m_vs_d),
    .frame_start (m_frame_start),
    .line_end    (m_line_end)
`ifdef VGA_FRAME_COUNTER_EN
    ,
    .frame_cnt   (m_frame_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " DrawX"},       32'(DrawX),       32'd0);
    check({tag, " DrawY"},       32'(DrawY),       32'd0);
    check({tag, " blank"},       32'(blank),       32'd1);
    check({tag, " hs"},          32'(hs),          32'd1);
    check({tag, " vs"},          32'(vs),          32'd1);
    check({tag, " hs_d"},        32'(hs_d),        32'd1);
    check({tag, " vs_d"},        32'(vs_d),        32'd1);
    check({tag, " frame_start"}, 32'(frame_start), 32'd0);
    check({tag, " line_end"},    32'(line_end),    32'd0);
`ifdef VGA_FRAME_COUNTER_EN
    check({tag, " frame_cnt"},   32'(frame_cnt),   32'd0);
`endif
  endtask

  initial begin
    int ex, ey, mx, my;
    logic exp_hs, prev_hs, m_exp_hs, m_exp_vs, m_prev_hs, m_prev_vs;
    int hs_low, blank_cnt, m_vs_low, m_blank_cnt;

    // Power-on reset held across clock edges.
    repeat (3) @(posedge vga_clk);
    @(negedge vga_clk);
    check_reset_values("por");
    reset = 1'b0;
    @(negedge vga_clk);
    check("por release DrawX", 32'(DrawX), 32'd1);
    check("por release DrawY", 32'(DrawY), 32'd0);

    // Run to DrawX=300, then assert reset between clock edges.
    repeat (299) @(negedge vga_clk);
    check("pre reset DrawX", 32'(DrawX), 32'd300);
    #5 reset = 1'b1;
    #1 check_reset_values("async");
    @(negedge vga_clk);
    check_reset_values("held");
    reset = 1'b0;

    // Cycle-by-cycle scan of lines 0..11 (k = edges since release).
    prev_hs = 1'b1; m_prev_hs = 1'b1; m_prev_vs = 1'b1;
    hs_low = 0; blank_cnt = 0; m_vs_low = 0; m_blank_cnt = 0;
    for (int k = 1; k < 9600; k++) begin
      @(negedge vga_clk);
      ex = k % 800;
      ey = k / 800;
      exp_hs = !(ex >= 656 && ex <= 751);
      check("DrawX", 32'(DrawX), 32'(ex));
      check("DrawY", 32'(DrawY), 32'(ey));
      check("blank", 32'(blank), 32'(ex < 640 && ey < 480));
      check("hs", 32'(hs), 32'(exp_hs));
      check("vs", 32'(vs), 32'd1);
      check("hs_d", 32'(hs_d), 32'(prev_hs));
      check("line_end", 32'(line_end), 32'(ex == 799));
      check("frame_start", 32'(frame_start), 32'd0);
      prev_hs = exp_hs;
      if (hs == 1'b0) hs_low++;
      if (blank == 1'b1) blank_cnt++;
      if (ex == 640) check("blank off at x640", 32'(blank), 32'd0);
      if (ex == 799 && ey == 10) check("line_end y10", 32'(line_end), 32'd1);
      if (ex == 0 && ey == 11) begin
        check("wrap y11 DrawY", 32'(DrawY), 32'd11);
        check("wrap y11 line_end", 32'(line_end), 32'd0);
      end
      if (ex == 799) begin
        if (ey >= 1) begin
          check("hs low per line", 32'(hs_low), 32'd96);
          check("blank per line", 32'(blank_cnt), 32'd640);
        end
        hs_low = 0;
        blank_cnt = 0;
      end

      // Reduced raster.
      mx = k % 16;
      my = (k / 16) % 10;
      m_exp_hs = !(mx >= 10 && mx <= 12);
      m_exp_vs = !(my >= 6 && my <= 7);
      check("m DrawX", 32'(m_DrawX), 32'(mx));
      check("m DrawY", 32'(m_DrawY), 32'(my));
      check("m blank", 32'(m_blank), 32'(mx < 8 && my < 4));
      check("m hs", 32'(m_hs), 32'(m_exp_hs));
      check("m vs", 32'(m_vs), 32'(m_exp_vs));
      check("m hs_d", 32'(m_hs_d), 32'(m_prev_hs));
      check("m vs_d", 32'(m_vs_d), 32'(m_prev_vs));
      check("m line_end", 32'(m_line_end), 32'(mx == 15));
      check("m frame_start", 32'(m_frame_start), 32'(mx == 0 && my == 0));
      m_prev_hs = m_exp_hs;
      m_prev_vs = m_exp_vs;
      if (m_vs == 1'b0) m_vs_low++;
      if (m_blank == 1'b1) m_blank_cnt++;
      if (mx == 0 && my == 6) check("m vs starts y6 x0", 32'(m_vs), 32'd0);
      if (mx == 0 && my == 0) check("m frame wrap blank", 32'(m_blank), 32'd1);
      if (mx == 0 && my == 4) check("m blank off at y4", 32'(m_blank), 32'd0);
      if (mx == 15 && my == 9) begin
        if (k >= 160) begin
          check("m vs low per frame", 32'(m_vs_low), 32'd32);
          check("m blank per frame", 32'(m_blank_cnt), 32'd32);
        end
        m_vs_low = 0;
        m_blank_cnt = 0;
      end
`ifdef VGA_FRAME_COUNTER_EN
      if (k == 480) begin
        check("m frame_cnt after 3 frames", 32'(m_frame_cnt), 32'd3);
        check("frame_cnt before first frame", 32'(frame_cnt), 32'd0);
      end
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_timing.md
VGA_SCAN_TIMING -- requirements
Module: vga_scan_timing

Interface
REQ-001 SHALL have port vga_clk, input, 1, the pixel clock (25 MHz); all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-003 SHALL have port DrawX, output, 10, the current horizontal pixel coordinate, 0..799.
REQ-004 SHALL have port DrawY, output, 10, the current line coordinate, 0..524.
REQ-005 SHALL have port blank, output, 1, display enable: 1 = visible pixel, 0 = blanking.
REQ-006 SHALL have port hs, output, 1, horizontal sync, active-low, aligned with DrawX/DrawY.
REQ-007 SHALL have port vs, output, 1, vertical sync, active-low, aligned with DrawX/DrawY.
REQ-008 SHALL have port hs_d, output, 1, hs delayed one vga_clk, aligned with the registered RGB of a one-cycle pixel pipeline.
REQ-009 SHALL have port vs_d, output, 1, vs delayed one vga_clk.
REQ-010 SHALL have port frame_start, output, 1, one-cycle pulse while DrawX=0 and DrawY=0.
REQ-011 SHALL have port line_end, output, 1, one-cycle pulse while DrawX=799.

Function
REQ-012 SHALL increment DrawX every cycle, wrapping 799->0.
REQ-013 SHALL increment DrawY only in the cycle DrawX wraps, and SHALL wrap DrawY 524->0 when both wrap together.
REQ-014 SHALL drive blank=1 iff DrawX<640 and DrawY<480.
REQ-015 SHALL drive hs=0 iff 656<=DrawX<=751 (front porch 640-655, back porch 752-799).
REQ-016 SHALL drive vs=0 iff 490<=DrawY<=491 (front porch 480-489, back porch 492-524).
REQ-017 SHALL register all outputs; blank/hs/vs/frame_start/line_end SHALL be decoded from next-state counter values so they are coincident with DrawX/DrawY (zero relative latency).
REQ-018 SHALL hold hs_d/vs_d equal to hs/vs of the previous cycle.
REQ-019 SHALL use only unsigned 10-bit counters; no value outside REQ-003/004 ranges SHALL ever appear.
REQ-020 SHALL produce exactly 800x525 = 420000 cycles between consecutive frame_start pulses.

Reset
REQ-021 SHALL on reset assertion immediately force DrawX=0, DrawY=0, blank=1, hs=1, vs=1, hs_d=1, vs_d=1, frame_start=0, line_end=0, regardless of clock.
REQ-022 SHALL, when reset is asserted mid-frame, discard the partial frame; the first cycle after release SHALL show DrawX=1, DrawY=0 (the reset cycle counts as pixel 0,0).
REQ-023 SHALL keep frame_start=0 during reset; the first frame_start SHALL occur 420000 cycles after release minus one.

Configuration
REQ-024 SHALL, with macro VGA_FRAME_COUNTER_EN defined, add output frame_cnt (16 bits), reset 0, incremented in the cycle frame_start asserts, wrapping 65535->0.
REQ-025 SHALL, without VGA_FRAME_COUNTER_EN, omit the frame_cnt port and its logic entirely; all other behaviour is unchanged.

Structure
REQ-026 SHALL take H_VISIBLE=640, H_FP=16, H_SYNC=96, H_TOTAL=800, V_VISIBLE=480, V_FP=10, V_SYNC=2, V_TOTAL=525 from shared package vga_timing_pkg; the package SHALL also hold the coordinate typedef (10-bit unsigned).
REQ-027 SHALL instantiate sub-module vga_axis_counter twice (horizontal, vertical), each parameterised by visible/fp/sync/total, with count-enable input, wrap output, active and sync-active outputs.

Verification
REQ-028 SHALL verify reset: assert reset asynchronously mid-line at DrawX=300 -> outputs match REQ-021 before the next edge; after release, DrawX=1, DrawY=0.
REQ-029 SHALL verify horizontal wrap: at DrawX=799, DrawY=10 -> line_end=1; next cycle DrawX=0, DrawY=11, line_end=0.
REQ-030 SHALL verify frame wrap: at DrawX=799, DrawY=524 -> next cycle DrawX=0, DrawY=0, frame_start=1, blank=1.
REQ-031 SHALL verify sync windows over one full frame: hs low for exactly 96 cycles per line starting at DrawX=656; vs low for exactly 1600 cycles starting at DrawY=490, DrawX=0; hs_d/vs_d lag by exactly one cycle.
REQ-032 SHALL verify blank count: exactly 307200 cycles with blank=1 per frame; blank=0 at DrawX=640 and at DrawY=480.
REQ-033 SHALL verify with VGA_FRAME_COUNTER_EN: after 3 full frames following reset, frame_cnt=3; build without the macro compiles with no frame_cnt port.
